div_unit: RTL

Iterative signed 32-bit divider for the multi-cycle MIPS datapath; the inverse counterpart of the existing `Mult` unit. The control unit pulses `DivInit` with operands on `A_Out`/`B_Out`, and the unit returns the MIPS `DIV` results. The quotient goes to LO (`Div_Low_Out`) and the remainder to HI (`Div_High_Out`), with a one-cycle `DivStop` completion pulse. A divide-by-zero trap, `DivZero`, is available at compile time.

---
 rtl/div_pkg.sv | 10 +
 rtl/div_unit_if.sv | 22 ++
 rtl/div_core.sv | 23 ++
 rtl/div_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative signed divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

    localparam int DIV_W     = 32;
    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = 6;

endpackage

// File: rtl/div_unit_if.sv
// Control-unit <-> divider bus: operands, start request, results and completion flags.
interface div_unit_if import div_pkg::*; #(parameter int DATA_W = DIV_W);

    logic [DATA_W-1:0] A_Out;
    logic [DATA_W-1:0] B_Out;
    logic              DivInit;
    logic              DivStop;
    logic              DivZero;
    logic [DATA_W-1:0] Div_High_Out;
    logic [DATA_W-1:0] Div_Low_Out;

    modport master (
        output A_Out, B_Out, DivInit,
        input  DivStop, DivZero, Div_High_Out, Div_Low_Out
    );

    modport slave (
        input  A_Out, B_Out, DivInit,
        output DivStop, DivZero, Div_High_Out, Div_Low_Out
    );

endinterface

// File: rtl/div_core.sv
// One unsigned restoring shift-subtract step: shifts the next dividend bit out of q into rem.
module div_core import div_pkg::*; #(
    parameter int DATA_W = DIV_W
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] q,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] q_next
);

    logic [DATA_W:0] rem_sh;
    logic            take;

    // rem stays below the divisor (<= 2^(DATA_W-1)), so the difference always fits DATA_W bits
    always_comb begin
        rem_sh   = {rem, q[DATA_W-1]};
        take     = (rem_sh >= {1'b0, divisor});
        rem_next = take ? (rem_sh[DATA_W-1:0] - divisor) : rem_sh[DATA_W-1:0];
        q_next   = {q[DATA_W-2:0], take};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative signed divider for MIPS DIV: LO = quotient, HI = remainder, 34-edge latency.
// Optional divide-by-zero trap enabled by defining DIV_ZERO_TRAP_EN.
module div_unit import div_pkg::*; #(
    parameter int DATA_W = DIV_W
) (
    input  logic       clk,
    input  logic       Reset_Out,
    div_unit_if.slave  bus
);

    div_state_t state, state_next;

    logic [DIV_CNT_W-1:0] count;
    logic [DATA_W-1:0]    abs_b, rem, q;
    logic [DATA_W-1:0]    rem_step, q_step;
    logic [DATA_W-1:0]    abs_a_in, abs_b_in;
    logic [DATA_W-1:0]    hi_q, lo_q;
    logic                 sign_q, sign_r;
    logic                 stop_q;
    logic                 accept, last_iter, zero_div, write_en;

    // |0x80..0| is 0x80..0 when read as unsigned, so DATA_W bits hold every magnitude
    assign abs_a_in  = bus.A_Out[DATA_W-1] ? -bus.A_Out : bus.A_Out;
    assign abs_b_in  = bus.B_Out[DATA_W-1] ? -bus.B_Out : bus.B_Out;
    assign last_iter = (count == DIV_CNT_W'(DATA_W - 1));

    div_core #(.DATA_W(DATA_W)) u_core (
        .rem      (rem),
        .q        (q),
        .divisor  (abs_b),
        .rem_next (rem_step),
        .q_next   (q_step)
    );

`ifdef DIV_ZERO_TRAP_EN
    logic zflag, zero_q;

    assign zero_div = (bus.B_Out == '0);
    assign write_en = ~zflag;

    always_ff @(posedge clk or posedge Reset_Out) begin
        if (Reset_Out) begin
            zflag  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (accept)
                zflag <= zero_div;
            zero_q <= (state == FIX) && zflag;
        end
    end

    assign bus.DivZero = zero_q;
`else
    assign zero_div    = 1'b0;
    assign write_en    = 1'b1;
    assign bus.DivZero = 1'b0;
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.DivInit) begin
                    accept     = 1'b1;
                    state_next = zero_div ? FIX : RUN;
                end
            end
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset_Out) begin
        if (Reset_Out)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge Reset_Out) begin
        if (Reset_Out) begin
            count  <= '0;
            abs_b  <= '0;
            rem    <= '0;
            q      <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            stop_q <= 1'b0;
        end else begin
            stop_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        abs_b  <= abs_b_in;
                        q      <= abs_a_in;
                        rem    <= '0;
                        count  <= '0;
                        sign_q <= bus.A_Out[DATA_W-1] ^ bus.B_Out[DATA_W-1];
                        sign_r <= bus.A_Out[DATA_W-1];
                    end
                end
                RUN: begin
                    rem   <= rem_step;
                    q     <= q_step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (write_en) begin
                        lo_q <= sign_q ? -q : q;
                        hi_q <= sign_r ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.DivStop      = stop_q;
    assign bus.Div_High_Out = hi_q;
    assign bus.Div_Low_Out  = lo_q;

endmodule
